// File: rtl/spi_flash_word_reader_if.sv
// Request/response bundle between the bus adapter and the flash word reader.
// Master issues word reads; slave answers with a one-cycle response pulse.
interface spi_flash_word_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/spi_flash_word_reader.sv
// SPI READ (0x03) fetch engine returning 32-bit little-endian words.
// Optional macro FLASH_CONT_READ_EN keeps csb low to stream sequential words.
module spi_flash_word_reader #(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 0
) (
    input  logic                     clock,
    input  logic                     resetb,
    spi_flash_word_reader_if.slave   bus,
    output logic                     busy,
    output logic                     flash_csb,
    output logic                     flash_clk,
    output logic                     flash_io0,
    input  logic                     flash_io1
);
    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] RISE = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FALL = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, DONE, GUARD, IDLE_CONT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   bits, bits_n;
    logic [31:0]   tx, tx_n;
    logic [31:0]   rx, rx_n;
    logic          csb, csb_n;
    logic          sck, sck_n;
    logic          mosi, mosi_n;
    logic          rvld, rvld_n;
    logic [31:0]   rdat, rdat_n;
    logic          seqrd, seqrd_n;
    logic [31:0]   frame;
    logic          tick_r, tick_f, last;
    logic          unused_addr;

`ifdef FLASH_CONT_READ_EN
    logic [21:0]   word, word_n;
    logic [21:0]   nxt;
    logic          seq;
    assign nxt = word + 22'd1;
    assign seq = (bus.req_addr[23:2] == nxt) && (nxt != '0);
`endif

    assign frame       = {8'h03, bus.req_addr[23:2], 2'b00};
    assign unused_addr = ^bus.req_addr[1:0];
    assign tick_r      = (cnt == RISE);
    assign tick_f      = (cnt == FALL);
    assign last        = (bits == '0);

    assign bus.req_ready = (state == IDLE) || (state == IDLE_CONT);
    assign busy          = !bus.req_ready;
    assign bus.rsp_valid = rvld;
    assign bus.rsp_data  = rdat;
    assign flash_csb     = csb;
    assign flash_clk     = sck;
    assign flash_io0     = mosi;

    // Next-state and datapath: bit engine shared by CMD/ADDR/DUMMY/DATA.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + ONE;
        bits_n  = bits;
        tx_n    = tx;
        rx_n    = rx;
        csb_n   = csb;
        sck_n   = sck;
        mosi_n  = mosi;
        rvld_n  = 1'b0;
        rdat_n  = rdat;
        seqrd_n = seqrd;
`ifdef FLASH_CONT_READ_EN
        word_n  = word;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.req_valid) begin
                    state_n = CMD;
                    csb_n   = 1'b0;
                    tx_n    = frame;
                    mosi_n  = frame[31];
                    bits_n  = 16'd7;
                    seqrd_n = 1'b0;
`ifdef FLASH_CONT_READ_EN
                    word_n  = bus.req_addr[23:2];
`endif
                end
            end
            CMD, ADDR, DUMMY, DATA: begin
                if (tick_r) begin
                    sck_n = 1'b1;
                    if (state == DATA) rx_n = {rx[30:0], flash_io1};
                end
                if (tick_f) begin
                    sck_n  = 1'b0;
                    cnt_n  = '0;
                    tx_n   = {tx[30:0], 1'b0};
                    mosi_n = tx[30];
                    bits_n = bits - 16'd1;
                    if (last) begin
                        unique case (state)
                            CMD: begin
                                state_n = ADDR;
                                bits_n  = 16'd23;
                            end
                            ADDR: begin
                                if (DUMMY_CYCLES > 0) begin
                                    state_n = DUMMY;
                                    bits_n  = 16'(DUMMY_CYCLES - 1);
                                end else begin
                                    state_n = DATA;
                                    bits_n  = 16'd31;
                                end
                            end
                            DUMMY: begin
                                state_n = DATA;
                                bits_n  = 16'd31;
                            end
                            default: begin
                                state_n = DONE;
                                cnt_n   = seqrd ? ONE : '0;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
`ifdef FLASH_CONT_READ_EN
                if (cnt == ONE) begin
                    rvld_n  = 1'b1;
                    rdat_n  = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                    state_n = IDLE_CONT;
                end
`else
                if (cnt == '0) csb_n = 1'b1;
                if (cnt == ONE) begin
                    rvld_n = 1'b1;
                    rdat_n = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                end
                if (cnt == FALL) state_n = IDLE;
`endif
            end
`ifdef FLASH_CONT_READ_EN
            IDLE_CONT: begin
                cnt_n = '0;
                if (bus.req_valid) begin
                    word_n = bus.req_addr[23:2];
                    if (seq) begin
                        state_n = DATA;
                        bits_n  = 16'd31;
                        seqrd_n = 1'b1;
                    end else begin
                        state_n = GUARD;
                        csb_n   = 1'b1;
                        tx_n    = frame;
                        mosi_n  = frame[31];
                        seqrd_n = 1'b0;
                    end
                end
            end
            GUARD: begin
                if (tick_f) begin
                    state_n = CMD;
                    csb_n   = 1'b0;
                    cnt_n   = '0;
                    bits_n  = 16'd7;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                csb_n   = 1'b1;
                sck_n   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops csb at once.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            tx    <= '0;
            rx    <= '0;
            csb   <= 1'b1;
            sck   <= 1'b0;
            mosi  <= 1'b0;
            rvld  <= 1'b0;
            rdat  <= '0;
            seqrd <= 1'b0;
`ifdef FLASH_CONT_READ_EN
            word  <= '0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bits  <= bits_n;
            tx    <= tx_n;
            rx    <= rx_n;
            csb   <= csb_n;
            sck   <= sck_n;
            mosi  <= mosi_n;
            rvld  <= rvld_n;
            rdat  <= rdat_n;
            seqrd <= seqrd_n;
`ifdef FLASH_CONT_READ_EN
            word  <= word_n;
`endif
        end
    end
endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Bench for spi_flash_word_reader: two instances (CLK_DIV=2/DUMMY=0 and
// CLK_DIV=1/DUMMY=8) against a behavioural SPI flash and word model.
module tb_spi_flash_word_reader;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:1023];
    logic        rstn [2];
    logic        rv   [2];
    logic [23:0] ra   [2];
    logic        rr   [2];
    logic        rspv [2];
    logic [31:0] rspd [2];
    logic        bsy  [2];
    logic        cs   [2];
    logic        sck  [2];
    logic        mosi [2];
    int          rises [2];
    int          nsel  [2];
    logic [31:0] cmdw  [2];
    int          lhi   [2];

    logic        cont_open [2];
    logic [21:0] prev_w    [2];

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return mem[a[9:0]];
    endfunction

    function automatic int cdiv(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int dcyc(input int g);
        return (g == 0) ? 0 : 8;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int CD = (g == 0) ? 2 : 1;
        localparam int DC = (g == 0) ? 0 : 8;

        spi_flash_word_reader_if bus ();
        logic        busy, csb, fclk, io0;
        logic        io1 = 1'b0;
        int          nr = 0;
        int          ns = 0;
        int          hr = 0;
        int          lh = 0;
        logic [31:0] sr = '0;

        assign bus.req_valid = rv[g];
        assign bus.req_addr  = ra[g];
        assign rr[g]    = bus.req_ready;
        assign rspv[g]  = bus.rsp_valid;
        assign rspd[g]  = bus.rsp_data;
        assign bsy[g]   = busy;
        assign cs[g]    = csb;
        assign sck[g]   = fclk;
        assign mosi[g]  = io0;
        assign rises[g] = nr;
        assign nsel[g]  = ns;
        assign cmdw[g]  = sr;
        assign lhi[g]   = lh;

        spi_flash_word_reader #(
            .CLK_DIV      (CD),
            .DUMMY_CYCLES (DC)
        ) dut (
            .clock     (clock),
            .resetb    (rstn[g]),
            .bus       (bus),
            .busy      (busy),
            .flash_csb (csb),
            .flash_clk (fclk),
            .flash_io0 (io0),
            .flash_io1 (io1)
        );

        // Flash: capture command+address on rising SCK edges.
        always @(posedge fclk or posedge csb) begin
            if (csb) begin
                nr <= 0;
            end else begin
                if (nr < 32) sr <= {sr[30:0], io0};
                nr <= nr + 1;
            end
        end

        always @(negedge csb) ns <= ns + 1;

        // Flash: shift out the byte stream on falling SCK edges.
        always @(negedge fclk) begin
            if (!csb && nr >= 32 + DC)
                io1 <= mem[10'(sr[9:0] + 10'((nr - 32 - DC) / 8))]
                          [3'(7 - ((nr - 32 - DC) % 8))];
        end

        // Length of the last csb-high stretch, in clocks.
        always @(negedge clock) begin
            if (csb === 1'b1) begin
                hr <= hr + 1;
            end else if (hr != 0) begin
                lh <= hr;
                hr <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int g);
        rstn[g] = 1'b0;
        rv[g]   = 1'b0;
        ra[g]   = '0;
        repeat (10) @(posedge clock);
        #1;
        check($sformatf("g%0d rst_csb", g), cs[g], 1);
        check($sformatf("g%0d rst_clk", g), sck[g], 0);
        check($sformatf("g%0d rst_io0", g), mosi[g], 0);
        check($sformatf("g%0d rst_rdy", g), rr[g], 1);
        check($sformatf("g%0d rst_rv", g), rspv[g], 0);
        check($sformatf("g%0d rst_rd", g), rspd[g], 0);
        check($sformatf("g%0d rst_busy", g), bsy[g], 0);
        @(negedge clock);
        rstn[g] = 1'b1;
        cont_open[g] = 1'b0;
    endtask

    task automatic do_read(input int g, input logic [23:0] a);
        int          n;
        int          ns0;
        int          lat;
        logic        seq;
        logic [23:0] base;
        logic [31:0] expd;
        base = {a[23:2], 2'b00};
        expd = {fbyte(base + 24'd3), fbyte(base + 24'd2),
                fbyte(base + 24'd1), fbyte(base)};
`ifdef FLASH_CONT_READ_EN
        seq = cont_open[g] && (a[23:2] == prev_w[g] + 22'd1)
              && (a[23:2] != '0);
        if (seq) lat = 1 + 64 * cdiv(g);
        else lat = (cont_open[g] ? 2 * cdiv(g) : 0)
                   + 2 + (64 + dcyc(g)) * 2 * cdiv(g);
`else
        seq = 1'b0;
        lat = 2 + (64 + dcyc(g)) * 2 * cdiv(g);
`endif
        @(negedge clock);
        rv[g] = 1'b1;
        ra[g] = a;
        n = 0;
        while (!rr[g] && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("g%0d rdy_wait", g), n < 2000, 1);
        ns0 = nsel[g];
        @(posedge clock);
        #1 rv[g] = 1'b0;
        check($sformatf("g%0d busy_acc", g), bsy[g], 1);
        check($sformatf("g%0d rdy_acc", g), rr[g], 0);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!rspv[g] && n < 3000);
        check($sformatf("g%0d lat %h", g, a), n, lat);
        check($sformatf("g%0d data %h", g, a), rspd[g], expd);
        check($sformatf("g%0d csel %h", g, a), nsel[g] - ns0, seq ? 0 : 1);
        if (!seq) begin
            check($sformatf("g%0d cmd %h", g, a), cmdw[g], {8'h03, base});
            check($sformatf("g%0d guard", g), lhi[g] >= 2 * cdiv(g), 1);
        end
        @(posedge clock);
        #1;
        check($sformatf("g%0d pulse", g), rspv[g], 0);
        check($sformatf("g%0d hold", g), rspd[g], expd);
`ifdef FLASH_CONT_READ_EN
        cont_open[g] = 1'b1;
`else
        cont_open[g] = 1'b0;
`endif
        prev_w[g] = a[23:2];
    endtask

    task automatic do_abort(input int g, input logic [23:0] a);
        int   n;
        logic seen;
        @(negedge clock);
        rv[g] = 1'b1;
        ra[g] = a;
        n = 0;
        while (!rr[g] && n < 2000) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 rv[g] = 1'b0;
        n = 0;
        while (rises[g] < 16 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("g%0d abort_reach", g), n < 1000, 1);
        rstn[g] = 1'b0;
        #1;
        check($sformatf("g%0d abort_csb", g), cs[g], 1);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1 seen |= rspv[g];
        end
        @(negedge clock);
        rstn[g] = 1'b1;
        cont_open[g] = 1'b0;
        repeat (300) begin
            @(posedge clock);
            #1 seen |= rspv[g];
        end
        check($sformatf("g%0d abort_rsp", g), seen, 0);
        check($sformatf("g%0d abort_rd", g), rspd[g], 0);
        check($sformatf("g%0d abort_csb2", g), cs[g], 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [23:0] a;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h60; mem[17] = 8'hAB; mem[18] = 8'h00; mem[19] = 8'h00;
        mem[20] = 8'h61; mem[21] = 8'hAB; mem[22] = 8'h00; mem[23] = 8'h00;
        for (int g = 0; g < 2; g++) begin
            rstn[g] = 1'b0;
            rv[g] = 1'b0;
            ra[g] = '0;
            cont_open[g] = 1'b0;
            prev_w[g] = '0;
        end
        for (int g = 0; g < 2; g++) begin
            do_reset(g);
            do_read(g, 24'h000012);
            check($sformatf("g%0d word0", g), rspd[g], 32'h0000AB60);
            do_read(g, 24'h000014);
            check($sformatf("g%0d word1", g), rspd[g], 32'h0000AB61);
            do_read(g, 24'h000100);
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 1) == 1)
                    a = {prev_w[g] + 22'd1, 2'($urandom)};
                else
                    a = 24'($urandom_range(0, 1023));
                do_read(g, a);
            end
            do_reset(g);
            do_abort(g, 24'h000020);
            do_read(g, 24'h000014);
            rstn[g] = 1'b0;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
